// File: rtl/pshare_predictor_param.sv
// Per-address (PShare) branch predictor: per-PC local histories index a shared
// table of 2-bit saturating counters, with a hardware init sweep after reset.
module pshare_predictor_param #(
    parameter int ADDR_W      = 32,
    parameter int PC_IDX_BITS = 4,
    parameter int HIST_BITS   = 6,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pred_valid_i,
    input  logic [ADDR_W-1:0] pred_pc_i,
    output logic              pred_ready_o,
    output logic              pred_valid_o,
    output logic              pred_taken_o,
    input  logic              upd_valid_i,
    input  logic [ADDR_W-1:0] upd_pc_i,
    input  logic              upd_taken_i,
    input  logic              upd_pred_i,
    output logic [CNT_W-1:0]  total_branch_o,
    output logic [CNT_W-1:0]  mispredict_o
);

    localparam int BHT_ENTRIES = 1 << PC_IDX_BITS;
    localparam int PHT_ENTRIES = 1 << HIST_BITS;
    localparam int SWEEP_BITS  = (PC_IDX_BITS > HIST_BITS) ? PC_IDX_BITS : HIST_BITS;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t state_q, state_d;

    logic [SWEEP_BITS-1:0] sweep_idx;
    logic                  sweep_done;
    logic                  run;
    logic                  pred_fire;
    logic                  upd_fire;

    logic [HIST_BITS-1:0] bht [BHT_ENTRIES];
    logic [1:0]           pht [PHT_ENTRIES];

    logic [PC_IDX_BITS-1:0] pred_bht_idx;
    logic [HIST_BITS-1:0]   pred_pht_idx;
    logic [PC_IDX_BITS-1:0] upd_bht_idx;
    logic [HIST_BITS-1:0]   upd_hist;
    logic [HIST_BITS-1:0]   upd_pht_idx;
    logic [1:0]             upd_ctr;
    logic [1:0]             upd_ctr_next;
    logic                   unused_pc_bits;

    assign sweep_done = (sweep_idx == '1);
    assign run        = (state_q == ST_RUN);
    assign pred_fire  = run && pred_valid_i;
    assign upd_fire   = run && upd_valid_i;

    assign pred_ready_o = run;

    // Only the word-index bits of the PCs select table entries.
    assign unused_pc_bits = ^{pred_pc_i, upd_pc_i};

    assign pred_bht_idx = pred_pc_i[PC_IDX_BITS+1:2];
    assign pred_pht_idx = bht[pred_bht_idx] ^ pred_pc_i[HIST_BITS+1:2];

    assign upd_bht_idx = upd_pc_i[PC_IDX_BITS+1:2];
    assign upd_hist    = bht[upd_bht_idx];
    assign upd_pht_idx = upd_hist ^ upd_pc_i[HIST_BITS+1:2];
    assign upd_ctr     = pht[upd_pht_idx];

    always_comb begin
        upd_ctr_next = upd_ctr;
        if (upd_taken_i) begin
            if (upd_ctr != 2'b11) begin
                upd_ctr_next = upd_ctr + 2'd1;
            end
        end else begin
            if (upd_ctr != 2'b00) begin
                upd_ctr_next = upd_ctr - 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: if (sweep_done) state_d = ST_RUN;
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sweep_idx <= '0;
        end else if (state_q == ST_INIT) begin
            sweep_idx <= sweep_idx + SWEEP_BITS'(1);
        end
    end

    // Table writes: the init sweep owns both tables until RUN; reads elsewhere
    // see pre-update contents, giving read-before-write on same-cycle accesses.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (state_q == ST_INIT) begin
                bht[sweep_idx[PC_IDX_BITS-1:0]] <= '0;
                pht[sweep_idx[HIST_BITS-1:0]]   <= 2'b01;
            end else if (upd_valid_i) begin
                bht[upd_bht_idx] <= {upd_hist[HIST_BITS-2:0], upd_taken_i};
                pht[upd_pht_idx] <= upd_ctr_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pred_valid_o   <= 1'b0;
            pred_taken_o   <= 1'b0;
            total_branch_o <= '0;
            mispredict_o   <= '0;
        end else begin
            pred_valid_o <= pred_fire;
            if (pred_fire) begin
                pred_taken_o <= pht[pred_pht_idx][1];
            end
            if (upd_fire) begin
                if (total_branch_o != '1) begin
                    total_branch_o <= total_branch_o + CNT_W'(1);
                end
                if ((upd_taken_i != upd_pred_i) && (mispredict_o != '1)) begin
                    mispredict_o <= mispredict_o + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_pshare_predictor_param.sv
// Directed bench for pshare_predictor_param: init sweep, training, saturation,
// same-cycle read-before-write, mid-run reset and statistics saturation.
module tb_pshare_predictor_param;

    logic        clk = 1'b0;
    logic        reset;
    logic        pred_valid;
    logic [31:0] pred_pc;
    logic        pred_ready_o;
    logic        pred_valid_o;
    logic        pred_taken_o;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic        upd_pred;
    logic [31:0] total_branch_o;
    logic [31:0] mispredict_o;

    logic        s_upd_valid;
    logic        s_pred_ready_o;
    logic        s_pred_valid_o;
    logic        s_pred_taken_o;
    logic [1:0]  s_total_branch_o;
    logic [1:0]  s_mispredict_o;

    int passed_count = 0;
    int total_count  = 0;
    int cycles;
    logic seen_valid;

    always #5 clk = ~clk;

    pshare_predictor_param dut (
        .clk            (clk),
        .reset          (reset),
        .pred_valid_i   (pred_valid),
        .pred_pc_i      (pred_pc),
        .pred_ready_o   (pred_ready_o),
        .pred_valid_o   (pred_valid_o),
        .pred_taken_o   (pred_taken_o),
        .upd_valid_i    (upd_valid),
        .upd_pc_i       (upd_pc),
        .upd_taken_i    (upd_taken),
        .upd_pred_i     (upd_pred),
        .total_branch_o (total_branch_o),
        .mispredict_o   (mispredict_o)
    );

    // Small instance with 2-bit statistics to reach counter saturation quickly.
    pshare_predictor_param #(
        .ADDR_W      (32),
        .PC_IDX_BITS (2),
        .HIST_BITS   (3),
        .CNT_W       (2)
    ) dut_small (
        .clk            (clk),
        .reset          (reset),
        .pred_valid_i   (1'b0),
        .pred_pc_i      (32'h0),
        .pred_ready_o   (s_pred_ready_o),
        .pred_valid_o   (s_pred_valid_o),
        .pred_taken_o   (s_pred_taken_o),
        .upd_valid_i    (s_upd_valid),
        .upd_pc_i       (upd_pc),
        .upd_taken_i    (upd_taken),
        .upd_pred_i     (upd_pred),
        .total_branch_o (s_total_branch_o),
        .mispredict_o   (s_mispredict_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        total_count++;
        assert (observed === expected) passed_count++;
        else begin
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic apply_predict(input string tag, input logic [31:0] pc,
                                 input logic exp_taken);
        pred_valid = 1'b1;
        pred_pc    = pc;
        tick();
        pred_valid = 1'b0;
        check_output({tag, "_valid"}, 64'(pred_valid_o), 64'(1'b1));
        check_output({tag, "_taken"}, 64'(pred_taken_o), 64'(exp_taken));
    endtask

    task automatic apply_update(input logic [31:0] pc, input logic taken, input logic pr);
        upd_valid = 1'b1;
        upd_pc    = pc;
        upd_taken = taken;
        upd_pred  = pr;
        tick();
        upd_valid = 1'b0;
    endtask

    // Holds request strobes high through INIT, counting cycles until ready.
    task automatic wait_init();
        cycles     = 0;
        seen_valid = 1'b0;
        pred_valid = 1'b1;
        pred_pc    = 32'h100;
        upd_valid  = 1'b1;
        upd_pc     = 32'h100;
        upd_taken  = 1'b1;
        upd_pred   = 1'b0;
        while (pred_ready_o !== 1'b1 && cycles < 200) begin
            tick();
            cycles++;
            if (pred_valid_o !== 1'b0) seen_valid = 1'b1;
        end
        pred_valid = 1'b0;
        upd_valid  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] simulation timeout");
    end

    initial begin
        reset       = 1'b0;
        pred_valid  = 1'b0;
        pred_pc     = '0;
        upd_valid   = 1'b0;
        upd_pc      = '0;
        upd_taken   = 1'b0;
        upd_pred    = 1'b0;
        s_upd_valid = 1'b0;

        // Reset for two cycles, then the init sweep.
        tick();
        tick();
        check_output("rst_ready", 64'(pred_ready_o), 64'(1'b0));
        check_output("rst_valid", 64'(pred_valid_o), 64'(1'b0));
        check_output("rst_taken", 64'(pred_taken_o), 64'(1'b0));
        check_output("rst_total", 64'(total_branch_o), 64'(0));
        check_output("rst_mis", 64'(mispredict_o), 64'(0));
        reset = 1'b1;
        wait_init();
        check_output("init_cycles", 64'(cycles), 64'(64));
        check_output("init_no_valid", 64'(seen_valid), 64'(1'b0));
        check_output("init_total", 64'(total_branch_o), 64'(0));
        check_output("init_mis", 64'(mispredict_o), 64'(0));

        // First prediction from a freshly swept table.
        apply_predict("p100_fresh", 32'h100, 1'b0);
        tick();
        check_output("valid_pulse", 64'(pred_valid_o), 64'(1'b0));

        // PHT[0] floors at 00; a wrapping counter would predict taken midway.
        for (int i = 0; i < 5; i++) begin
            apply_update(32'h0, 1'b0, 1'b0);
            apply_predict($sformatf("floor%0d", i), 32'h0, 1'b0);
        end
        check_output("floor_total", 64'(total_branch_o), 64'(5));
        check_output("floor_mis", 64'(mispredict_o), 64'(0));

        // Three taken updates: history 0->1->3->7, PHT[0]=01, PHT[1]=PHT[3]=10.
        for (int i = 0; i < 3; i++) apply_update(32'h100, 1'b1, 1'b0);
        check_output("t3_total", 64'(total_branch_o), 64'(8));
        check_output("t3_mis", 64'(mispredict_o), 64'(3));
        apply_predict("p100_h7", 32'h100, 1'b0);
        apply_predict("p00c_alias", 32'h0C, 1'b1);

        // History walks 15, 31, 63; PHT[63] needs one more taken to reach 10.
        for (int i = 0; i < 3; i++) apply_update(32'h100, 1'b1, 1'b0);
        apply_predict("p100_h63", 32'h100, 1'b0);
        apply_update(32'h100, 1'b1, 1'b0);
        apply_predict("p100_trained", 32'h100, 1'b1);
        check_output("t7_total", 64'(total_branch_o), 64'(12));
        check_output("t7_mis", 64'(mispredict_o), 64'(7));

        // Same-cycle predict and update on PC 0x40 (PHT[63^16]=01).
        pred_valid = 1'b1;
        pred_pc    = 32'h40;
        upd_valid  = 1'b1;
        upd_pc     = 32'h40;
        upd_taken  = 1'b1;
        upd_pred   = 1'b0;
        tick();
        pred_valid = 1'b0;
        upd_valid  = 1'b0;
        check_output("rbw_valid", 64'(pred_valid_o), 64'(1'b1));
        check_output("rbw_taken", 64'(pred_taken_o), 64'(1'b0));
        apply_predict("p40_after", 32'h40, 1'b1);
        check_output("rbw_total", 64'(total_branch_o), 64'(13));
        check_output("rbw_mis", 64'(mispredict_o), 64'(8));

        // One-cycle reset mid-stream restarts the full sweep.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check_output("mid_ready", 64'(pred_ready_o), 64'(1'b0));
        check_output("mid_taken", 64'(pred_taken_o), 64'(1'b0));
        check_output("mid_total", 64'(total_branch_o), 64'(0));
        check_output("mid_mis", 64'(mispredict_o), 64'(0));
        wait_init();
        check_output("reinit_cycles", 64'(cycles), 64'(64));
        check_output("reinit_no_valid", 64'(seen_valid), 64'(1'b0));
        check_output("reinit_total", 64'(total_branch_o), 64'(0));
        apply_predict("p40_reinit", 32'h40, 1'b0);
        apply_predict("p100_reinit", 32'h100, 1'b0);

        // Statistics saturation on the 2-bit instance.
        check_output("s_ready", 64'(s_pred_ready_o), 64'(1'b1));
        upd_pc    = 32'h0;
        upd_taken = 1'b1;
        upd_pred  = 1'b0;
        s_upd_valid = 1'b1;
        tick();
        tick();
        check_output("s_total2", 64'(s_total_branch_o), 64'(2));
        check_output("s_mis2", 64'(s_mispredict_o), 64'(2));
        tick();
        tick();
        tick();
        s_upd_valid = 1'b0;
        check_output("s_total_sat", 64'(s_total_branch_o), 64'(3));
        check_output("s_mis_sat", 64'(s_mispredict_o), 64'(3));
        check_output("s_no_valid", 64'(s_pred_valid_o), 64'(1'b0));
        check_output("s_no_taken", 64'(s_pred_taken_o), 64'(1'b0));
        check_output("main_idle_total", 64'(total_branch_o), 64'(0));

        $display("%0d/%0d checks passed", passed_count, total_count);
        $finish;
    end

endmodule
